// File: rtl/dtb_pkg.sv
// Shared types and lane-count helpers for the multi-lane trace buffer.
package dtb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACE = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } tracer_state_t;

  // log2 of the active lane count; lane selects beyond the maximum saturate.
  function automatic int unsigned lane_log(input int unsigned k, input int unsigned max_traces);
    int unsigned lmax;
    lmax = $clog2(max_traces);
    return (k < lmax) ? k : lmax;
  endfunction

  function automatic int unsigned lanes(input int unsigned k, input int unsigned max_traces);
    return 32'd1 << lane_log(k, max_traces);
  endfunction

endpackage

// File: rtl/trace_word_buffer.sv
// One-entry prefetch buffer between the memory load handshake and the
// active replay word.
module trace_word_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             req_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             load_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Acknowledges arriving while no request is outstanding are dropped.
  assign load_o  = req_en_i && !valid_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i && load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/multi_lane_tracer.sv
// Multi-lane tracer: packs 1..MAX_TRACES lanes into memory words (trace mode)
// or replays prefetched memory words as parallel lane streams (stream mode).
module multi_lane_tracer
  import dtb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_TRACES = 8
) (
  input  logic                          FPGA_CLK_I,
  input  logic                          RST_NI,
  input  logic                          EN_I,
  input  logic                          MODE_I,
  input  logic [$clog2(MAX_TRACES)-1:0] NTRACE_I,
  input  logic                          FPGA_TRIG_I,
  input  logic [MAX_TRACES-1:0]         FPGA_TRACE_I,
  output logic [MAX_TRACES-1:0]         FPGA_TRACE_O,
  output logic                          FPGA_TRIG_O,
  input  logic                          TRG_EVENT_I,
  output logic                          TRG_EVENT_O,
  output logic [$clog2(WIDTH)-1:0]      EVENT_POS_O,
  output logic [WIDTH-1:0]              DATA_O,
  output logic                          STORE_O,
  input  logic [WIDTH-1:0]              DATA_I,
  output logic                          LOAD_O,
  input  logic                          LOAD_I,
  output logic                          UNDERRUN_O
);

  localparam int KW = $clog2(MAX_TRACES);
  localparam int BW = $clog2(WIDTH);

  tracer_state_t state_q, state_d;

  logic                  mode_q;
  logic [KW-1:0]         ntrace_q;
  logic                  cfg_change;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WIDTH-1:0]      trace_q, trace_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      active_q, active_d;
  logic                  active_valid_q, active_valid_d;
  logic                  store_q, store_d;
  logic                  sticky_q, sticky_d;
  logic                  underrun_q, underrun_d;
  logic [BW-1:0]         event_pos_q, event_pos_d;
  logic [MAX_TRACES-1:0] trace_dly_q;

  int unsigned           ll;
  logic [MAX_TRACES-1:0] lane_mask;
  logic [BW-1:0]         last_beat;
  logic [BW-1:0]         bit_pos;
  logic                  at_last;
  logic [WIDTH-1:0]      lane_word_mask;
  logic [WIDTH-1:0]      lane_word_data;
  logic [MAX_TRACES-1:0] stream_lanes;

  logic                  buf_clear;
  logic                  buf_pop;
  logic                  buf_valid;
  logic [WIDTH-1:0]      buf_data;

  assign ll             = lane_log(32'(NTRACE_I), MAX_TRACES);
  assign lane_mask      = ~({MAX_TRACES{1'b1}} << lanes(32'(NTRACE_I), MAX_TRACES));
  assign last_beat      = BW'((WIDTH >> ll) - 1);
  assign bit_pos        = BW'(32'(beat_q) << ll);
  assign at_last        = (beat_q == last_beat);
  assign lane_word_mask = WIDTH'(lane_mask) << bit_pos;
  assign lane_word_data = WIDTH'(FPGA_TRACE_I & lane_mask) << bit_pos;
  assign stream_lanes   = MAX_TRACES'(active_q >> bit_pos) & lane_mask;
  assign cfg_change     = (MODE_I != mode_q) || (NTRACE_I != ntrace_q);

  trace_word_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i    (FPGA_CLK_I),
    .rst_ni   (RST_NI),
    .clear_i  (buf_clear),
    .req_en_i (EN_I && MODE_I),
    .data_i   (DATA_I),
    .load_i   (LOAD_I),
    .load_o   (LOAD_O),
    .pop_i    (buf_pop),
    .data_o   (buf_data),
    .valid_o  (buf_valid)
  );

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    trace_d        = trace_q;
    data_d         = data_q;
    store_d        = 1'b0;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    sticky_d       = sticky_q;
    event_pos_d    = event_pos_q;
    underrun_d     = underrun_q;
    buf_clear      = 1'b0;
    buf_pop        = 1'b0;

    if (cfg_change) begin
      state_d        = ST_IDLE;
      beat_d         = '0;
      active_valid_d = 1'b0;
      buf_clear      = 1'b1;
      sticky_d       = 1'b0;
      event_pos_d    = '0;
      underrun_d     = 1'b0;
    end else if (!EN_I) begin
      state_d = ST_IDLE;
    end else if (!MODE_I) begin
      // Capture starts on the first enabled cycle, not one state later.
      state_d = ST_TRACE;
      trace_d = (trace_q & ~lane_word_mask) | lane_word_data;
      if (FPGA_TRIG_I) begin
        sticky_d = 1'b1;
        if (!sticky_q) event_pos_d = bit_pos;
      end
      if (at_last) begin
        beat_d  = '0;
        data_d  = trace_d;
        store_d = 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (FPGA_TRIG_I) begin
            if (at_last) begin
              beat_d = '0;
              if (buf_valid) begin
                active_d = buf_data;
                buf_pop  = 1'b1;
              end else begin
                active_valid_d = 1'b0;
                underrun_d     = 1'b1;
                state_d        = ST_FILL;
              end
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (buf_valid) begin
            active_d       = buf_data;
            active_valid_d = 1'b1;
            buf_pop        = 1'b1;
            beat_d         = '0;
            state_d        = ST_RUN;
          end
        end
        default: begin
          // Resuming after a pause keeps a still-valid active word.
          state_d = active_valid_q ? ST_RUN : ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q        <= ST_IDLE;
      mode_q         <= 1'b0;
      ntrace_q       <= '0;
      beat_q         <= '0;
      trace_q        <= '0;
      data_q         <= '0;
      store_q        <= 1'b0;
      active_q       <= '0;
      active_valid_q <= 1'b0;
      sticky_q       <= 1'b0;
      event_pos_q    <= '0;
      underrun_q     <= 1'b0;
      trace_dly_q    <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= MODE_I;
      ntrace_q       <= NTRACE_I;
      beat_q         <= beat_d;
      trace_q        <= trace_d;
      data_q         <= data_d;
      store_q        <= store_d;
      active_q       <= active_d;
      active_valid_q <= active_valid_d;
      sticky_q       <= sticky_d;
      event_pos_q    <= event_pos_d;
      underrun_q     <= underrun_d;
      trace_dly_q    <= FPGA_TRACE_I;
    end
  end

  assign FPGA_TRACE_O = MODE_I ? ((state_q == ST_RUN) ? stream_lanes : '0) : trace_dly_q;
  assign FPGA_TRIG_O  = MODE_I ? (state_q == ST_RUN) : TRG_EVENT_I;
  assign TRG_EVENT_O  = FPGA_TRIG_I | sticky_q;
  assign EVENT_POS_O  = MODE_I ? '0 : event_pos_q;
  assign DATA_O       = data_q;
  assign STORE_O      = store_q;
  assign UNDERRUN_O   = underrun_q;

endmodule

// File: tb/tb_multi_lane_tracer.sv
// Directed bench for multi_lane_tracer: trace packing, trigger position,
// stream replay with prefetch, underrun and asynchronous reset.
module tb_multi_lane_tracer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [2:0]  ntrace;
  logic        trig_in;
  logic [7:0]  trace_in;
  logic [7:0]  trace_out;
  logic        trig_out;
  logic        trg_event_in;
  logic        trg_event_out;
  logic [4:0]  event_pos;
  logic [31:0] data_out;
  logic        store;
  logic [31:0] data_in;
  logic        load_req;
  logic        load_ack;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  multi_lane_tracer #(
    .WIDTH      (32),
    .MAX_TRACES (8)
  ) dut (
    .FPGA_CLK_I   (clk),
    .RST_NI       (rst_n),
    .EN_I         (en),
    .MODE_I       (mode),
    .NTRACE_I     (ntrace),
    .FPGA_TRIG_I  (trig_in),
    .FPGA_TRACE_I (trace_in),
    .FPGA_TRACE_O (trace_out),
    .FPGA_TRIG_O  (trig_out),
    .TRG_EVENT_I  (trg_event_in),
    .TRG_EVENT_O  (trg_event_out),
    .EVENT_POS_O  (event_pos),
    .DATA_O       (data_out),
    .STORE_O      (store),
    .DATA_I       (data_in),
    .LOAD_O       (load_req),
    .LOAD_I       (load_ack),
    .UNDERRUN_O   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] word;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; ntrace = 3'd0; trig_in = 1'b0;
    trace_in = 8'h00; trg_event_in = 1'b0; data_in = 32'h0; load_ack = 1'b0;
    step(); step();
    check("rst_data", data_out, 32'h0);
    check("rst_store", 32'(store), 32'h0);
    check("rst_load", 32'(load_req), 32'h0);
    check("rst_evpos", 32'(event_pos), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_trgev", 32'(trg_event_out), 32'h0);
    check("rst_trace_o", 32'(trace_out), 32'h0);
    trg_event_in = 1'b1; #1;
    check("rst_trig_pass", 32'(trig_out), 32'h1);
    trg_event_in = 1'b0;
    rst_n = 1'b1;
    step();

    $display("phase trace k=0 alternating lane0");
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      trace_in = (i % 2 == 0) ? 8'h01 : 8'h00;
      step();
      if (i == 0) check("daisy_chain", 32'(trace_out), 32'h01);
      if (i < 31) check("t1_no_store", 32'(store), 32'h0);
    end
    check("t1_store", 32'(store), 32'h1);
    check("t1_data", data_out, 32'h5555_5555);
    check("t1_trgev_low", 32'(trg_event_out), 32'h0);
    en = 1'b0; ntrace = 3'd3;
    step();
    check("t1_store_pulse", 32'(store), 32'h0);

    $display("phase trace k=3 pattern A5");
    en = 1'b1; trace_in = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_store", 32'(store), (i == 3) ? 32'h1 : 32'h0);
    end
    check("t2_data", data_out, 32'hA5A5_A5A5);

    $display("phase trace k=2 trigger at beat 5");
    en = 1'b0; ntrace = 3'd2;
    step();
    check("t3_evpos_clr", 32'(event_pos), 32'h0);
    check("t3_trgev_clr", 32'(trg_event_out), 32'h0);
    en = 1'b1; trace_in = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      trig_in = (i == 5 || i == 7);
      step();
      if (i == 5) check("t3_evpos_first", 32'(event_pos), 32'd20);
    end
    trig_in = 1'b0; #1;
    check("t3_trgev_sticky", 32'(trg_event_out), 32'h1);
    check("t3_evpos_kept", 32'(event_pos), 32'd20);
    check("t3_store", 32'(store), 32'h1);
    check("t3_data", data_out, 32'hFFFF_FFFF);

    $display("phase stream k=1 two words");
    en = 1'b0; mode = 1'b1; ntrace = 3'd1; trg_event_in = 1'b1;
    step();
    check("t4_evpos_stream", 32'(event_pos), 32'h0);
    check("t4_trgev_clr", 32'(trg_event_out), 32'h0);
    check("t4_trig_idle", 32'(trig_out), 32'h0);
    check("t4_load_dis", 32'(load_req), 32'h0);
    en = 1'b1; #1;
    check("t4_load_req", 32'(load_req), 32'h1);
    load_ack = 1'b1; data_in = 32'h1B1B_1B1B;
    step();
    load_ack = 1'b0;
    check("t4_load_drop", 32'(load_req), 32'h0);
    check("t4_trig_c1", 32'(trig_out), 32'h0);
    step();
    check("t4_trig_c2", 32'(trig_out), 32'h1);
    check("t4_load_again", 32'(load_req), 32'h1);
    load_ack = 1'b1; data_in = 32'hE4E4_E4E4; trig_in = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("t4_w0_lanes", 32'(trace_out), 32'(3 - (j % 4)));
      step();
      if (j == 0) load_ack = 1'b0;
    end
    for (int j = 0; j < 16; j++) begin
      check("t4_w1_valid", 32'(trig_out), 32'h1);
      check("t4_w1_lanes", 32'(trace_out), 32'(j % 4));
      step();
    end
    trig_in = 1'b0;
    check("t4_underrun", 32'(underrun), 32'h1);
    check("t4_trig_drop", 32'(trig_out), 32'h0);

    $display("phase stream k=1 single word underrun");
    en = 1'b0; mode = 1'b0;
    step();
    check("t5_underrun_clr", 32'(underrun), 32'h0);
    check("t5_trig_trace", 32'(trig_out), 32'h1);
    trg_event_in = 1'b0; mode = 1'b1;
    step();
    word = 32'h1234_5678;
    en = 1'b1; load_ack = 1'b1; data_in = word;
    step();
    load_ack = 1'b0;
    step();
    trig_in = 1'b1;
    for (int j = 0; j < 17; j++) begin
      check("t5_valid", 32'(trig_out), (j < 16) ? 32'h1 : 32'h0);
      if (j < 16) check("t5_lanes", 32'(trace_out), (word >> (2 * j)) & 32'h3);
      step();
    end
    trig_in = 1'b0;
    check("t5_underrun", 32'(underrun), 32'h1);
    check("t5_load_req", 32'(load_req), 32'h1);
    check("t5_trace_o_zero", 32'(trace_out), 32'h0);

    $display("phase reset mid-word k=3");
    en = 1'b0; mode = 1'b0; ntrace = 3'd3;
    step();
    en = 1'b1; trace_in = 8'hFF;
    step();
    trig_in = 1'b1;
    step();
    trig_in = 1'b0; #1;
    check("t6_evpos", 32'(event_pos), 32'd8);
    check("t6_trgev", 32'(trg_event_out), 32'h1);
    trg_event_in = 1'b1;
    rst_n = 1'b0; #1;
    check("t6_rst_data", data_out, 32'h0);
    check("t6_rst_store", 32'(store), 32'h0);
    check("t6_rst_evpos", 32'(event_pos), 32'h0);
    check("t6_rst_trgev", 32'(trg_event_out), 32'h0);
    check("t6_rst_trace_o", 32'(trace_out), 32'h0);
    check("t6_rst_underrun", 32'(underrun), 32'h0);
    check("t6_rst_trig", 32'(trig_out), 32'h1);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1; trace_in = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_store", 32'(store), (i == 3) ? 32'h1 : 32'h0);
    end
    check("t6_data", data_out, 32'h3C3C_3C3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
